// File: rtl/game_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : game_pkg                                                   |
// | Purpose : Shared types and constants for the round sequencer slice:  |
// |           state encoding, target one-hot codes, LFSR tap mask and    |
// |           counter widths, plus the LFSR index-to-target decoder.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package game_pkg;

  localparam int TGT_W     = 3;   // number of sensor targets
  localparam int WL_W      = 8;   // windows_left width
  localparam int WIN_CNT_W = 32;  // per-window cycle counter width
  localparam int LFSR_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PICK   = 2'd1,
    ST_WINDOW = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Plain-vector aliases of the enum encoding for the state register.
  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_PICK   = ST_PICK;
  localparam logic [1:0] S_WINDOW = ST_WINDOW;
  localparam logic [1:0] S_DONE   = ST_DONE;

  localparam logic [TGT_W-1:0] TGT0 = 3'b001;
  localparam logic [TGT_W-1:0] TGT1 = 3'b010;
  localparam logic [TGT_W-1:0] TGT2 = 3'b100;

  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7,5,4,3).
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  // Two LFSR bits give four codes for three targets; code 3 folds onto target 2.
  function automatic logic [TGT_W-1:0] tgt_from_idx(input logic [1:0] idx);
    logic [TGT_W-1:0] oh;
    case (idx)
      2'd0:    oh = TGT0;
      2'd1:    oh = TGT1;
      default: oh = TGT2;
    endcase
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : round_sequencer_if                                         |
// | Purpose : Bundle of round-control signals between the sequencer and  |
// |           the sensor / score / display side.                         |
// |   start         : level request to begin a game                      |
// |   hit_in[2:0]   : synchronous sensor levels, bit i = target i        |
// |   target_oh[2:0]: one-hot lit target, 0 when none is lit             |
// |   score_inc     : one-cycle pulse per scored hit                     |
// |   window_active : high during every scoring-window cycle             |
// |   windows_left  : windows not yet completed in the current game      |
// |   busy          : high while picking or in a window                  |
// |   game_over     : high once the game has finished                    |
// |   master = sequencer side, slave = environment side                  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface round_sequencer_if;
  import game_pkg::*;

  logic             start;
  logic [TGT_W-1:0] hit_in;
  logic [TGT_W-1:0] target_oh;
  logic             score_inc;
  logic             window_active;
  logic [WL_W-1:0]  windows_left;
  logic             busy;
  logic             game_over;

  modport master (
    input  start, hit_in,
    output target_oh, score_inc, window_active, windows_left, busy, game_over
  );

  modport slave (
    output start, hit_in,
    input  target_oh, score_inc, window_active, windows_left, busy, game_over
  );

endinterface
`default_nettype wire

// File: rtl/target_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : target_picker                                              |
// | Purpose : Supplies the next target to light.                         |
// |           RANDOM_TARGET_EN defined  : 8-bit Fibonacci LFSR, free     |
// |             running, index = lfsr[1:0] with 3 mapped to target 2.    |
// |           RANDOM_TARGET_EN undefined: round-robin 001,010,100,...    |
// |             rewound to 001 on restart.                               |
// | Ports   : clock, reset (sync, active-high), advance (step after a    |
// |           pick), restart (game start), target_oh (candidate target). |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module target_picker
  import game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             restart,
  output logic [TGT_W-1:0] target_oh
);

`ifdef RANDOM_TARGET_EN
  logic [LFSR_W-1:0] r_lfsr;
  logic              w_unused_ctl;

  // The LFSR free-runs, so the control strobes carry no information here.
  assign w_unused_ctl = advance ^ restart;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
    end
  end

  assign target_oh = tgt_from_idx(r_lfsr[1:0]);
`else
  logic [TGT_W-1:0]  r_ptr;
  logic [LFSR_W-1:0] w_seed_unused;

  assign w_seed_unused = LFSR_SEED;

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      r_ptr <= TGT0;
    end else if (advance) begin
      r_ptr <= {r_ptr[TGT_W-2:0], r_ptr[TGT_W-1]};
    end
  end

  assign target_oh = r_ptr;
`endif

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : round_sequencer                                            |
// | Purpose : Game-round controller. On start it runs NUM_WINDOWS timed  |
// |           windows of WINDOW_CYCLES cycles, lights one target per     |
// |           window and emits at most one score_inc per window, for the |
// |           first rising edge on the lit target's sensor.              |
// | Ports   : clock, reset (sync, active-high)                           |
// |           bus (round_sequencer_if.master): start, hit_in, target_oh, |
// |           score_inc, window_active, windows_left, busy, game_over    |
// | Config  : RANDOM_TARGET_EN selects LFSR targets in target_picker.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned       WINDOW_CYCLES = 100_000_000,
  parameter int unsigned       NUM_WINDOWS   = 30,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 8'hA5
) (
  input  logic               clock,
  input  logic               reset,
  round_sequencer_if.master  bus
);

  localparam logic [WIN_CNT_W-1:0] c_win_last    = WIN_CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [WL_W-1:0]      c_num_windows = WL_W'(NUM_WINDOWS);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [WIN_CNT_W-1:0] r_win_cnt;
  logic                 r_scored;
  logic [TGT_W-1:0]     r_hit_prev;
  logic [TGT_W-1:0]     w_rise;
  logic [TGT_W-1:0]     r_target_oh;
  logic [TGT_W-1:0]     w_pick_oh;
  logic [WL_W-1:0]      r_windows_left;
  logic [WL_W-1:0]      w_windows_left_dec;
  logic                 r_score_inc;
  logic                 r_window_active;
  logic                 r_busy;
  logic                 r_game_over;
  logic                 w_start_acc;
  logic                 w_win_end;
  logic                 w_hit_lit;
  logic                 w_pick;

  target_picker #(
    .LFSR_SEED (LFSR_SEED)
  ) u_picker (
    .clock     (clock),
    .reset     (reset),
    .advance   (w_pick),
    .restart   (w_start_acc),
    .target_oh (w_pick_oh)
  );

  // Edge history is refreshed every cycle regardless of state, so a sensor
  // already high when a window opens never counts as a new hit.
  always_ff @(posedge clock) begin
    r_hit_prev <= bus.hit_in;
  end

  assign w_rise      = bus.hit_in & ~r_hit_prev;
  assign w_start_acc = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start;
  assign w_pick      = (r_state == S_PICK);
  assign w_win_end   = (r_state == S_WINDOW) && (r_win_cnt == c_win_last);
  // r_target_oh is cleared after a score, so only the lit, unscored bit can fire.
  assign w_hit_lit   = (r_state == S_WINDOW) && !r_scored && (|(w_rise & r_target_oh));

  // Saturating decrement: windows_left bottoms out at zero.
  assign w_windows_left_dec = (r_windows_left != '0) ? (r_windows_left - 1'b1) : '0;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_state_nxt = S_PICK;
      end
      S_PICK: begin
        w_state_nxt = S_WINDOW;
      end
      S_WINDOW: begin
        if (w_win_end) begin
          w_state_nxt = (w_windows_left_dec == '0) ? S_DONE : S_PICK;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up
  // exactly with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_win_cnt       <= '0;
      r_scored        <= 1'b0;
      r_target_oh     <= '0;
      r_windows_left  <= '0;
      r_score_inc     <= 1'b0;
      r_window_active <= 1'b0;
      r_busy          <= 1'b0;
      r_game_over     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_score_inc     <= w_hit_lit;
      r_window_active <= (w_state_nxt == S_WINDOW);
      r_busy          <= (w_state_nxt == S_PICK) || (w_state_nxt == S_WINDOW);
      r_game_over     <= (w_state_nxt == S_DONE);

      if (w_start_acc) begin
        r_windows_left <= c_num_windows;
      end else if (w_win_end) begin
        r_windows_left <= w_windows_left_dec;
      end

      case (r_state)
        S_PICK: begin
          r_target_oh <= w_pick_oh;
          r_win_cnt   <= '0;
          r_scored    <= 1'b0;
        end
        S_WINDOW: begin
          r_win_cnt <= r_win_cnt + 1'b1;
          if (w_hit_lit) r_scored <= 1'b1;
          if (w_hit_lit || w_win_end) r_target_oh <= '0;
        end
        default: begin
          r_target_oh <= '0;
        end
      endcase
    end
  end

  assign bus.target_oh     = r_target_oh;
  assign bus.score_inc     = r_score_inc;
  assign bus.window_active = r_window_active;
  assign bus.windows_left  = r_windows_left;
  assign bus.busy          = r_busy;
  assign bus.game_over     = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_round_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_round_sequencer                                         |
// | Purpose : Directed self-checking bench for round_sequencer with      |
// |           WINDOW_CYCLES=8, NUM_WINDOWS=3 (round-robin targets).      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_round_sequencer;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   t0;
  logic [2:0] hv [8];

  round_sequencer_if bus ();

  round_sequencer #(
    .WINDOW_CYCLES (8),
    .NUM_WINDOWS   (3),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required summary before 200000");
    $fatal(1, "watchdog expired");
  end

  // Advance n clock edges; sample and drive 1 time unit after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      $error("comparison %s differs", tag);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk(tag, 32'({bus.target_oh, bus.score_inc, bus.window_active,
                  bus.windows_left, bus.busy, bus.game_over}), 32'd0);
  endtask

  task automatic chk_done(input string tag, input logic exp_score);
    chk({tag, "_over"},  32'(bus.game_over),     32'd1);
    chk({tag, "_busy"},  32'(bus.busy),          32'd0);
    chk({tag, "_wact"},  32'(bus.window_active), 32'd0);
    chk({tag, "_tgt"},   32'(bus.target_oh),     32'd0);
    chk({tag, "_left"},  32'(bus.windows_left),  32'd0);
    chk({tag, "_score"}, 32'(bus.score_inc),     32'(exp_score));
  endtask

  // Entered in a PICK cycle; covers PICK plus the 8 window cycles and
  // leaves the bench in the cycle following the window end.
  task automatic window_run(input string tag, input logic [2:0] exp_tgt,
                            input logic [7:0] exp_left, input logic exp_pick_score,
                            input logic [2:0] pick_hit, input logic [2:0] hits [8],
                            input int score_at);
    bus.hit_in = pick_hit;
    chk({tag, "_pick_busy"},  32'(bus.busy),          32'd1);
    chk({tag, "_pick_wact"},  32'(bus.window_active), 32'd0);
    chk({tag, "_pick_tgt"},   32'(bus.target_oh),     32'd0);
    chk({tag, "_pick_left"},  32'(bus.windows_left),  32'(exp_left));
    chk({tag, "_pick_score"}, 32'(bus.score_inc),     32'(exp_pick_score));
    for (int c = 0; c < 8; c++) begin
      tick(1);
      bus.hit_in = hits[c];
      chk($sformatf("%s_c%0d_tgt", tag, c), 32'(bus.target_oh),
          32'(((score_at >= 0) && (c >= score_at)) ? 3'b000 : exp_tgt));
      chk($sformatf("%s_c%0d_wact", tag, c), 32'(bus.window_active), 32'd1);
      chk($sformatf("%s_c%0d_score", tag, c), 32'(bus.score_inc), 32'(c == score_at));
      chk($sformatf("%s_c%0d_left", tag, c), 32'(bus.windows_left), 32'(exp_left));
    end
    tick(1);
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.hit_in = 3'b000;
    tick(3);
    chk_quiet("reset_state");
    reset = 1'b0;

    // Idle with no start: everything stays low.
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk_quiet($sformatf("idle_%0d", i));
    end

    // Game 1: round-robin targets, no hits, game length from start.
    bus.start = 1'b1;
    t0 = cyc;
    tick(1);
    bus.start = 1'b0;
    hv = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    window_run("g1w1", 3'b001, 8'd3, 1'b0, 3'b000, hv, -1);
    window_run("g1w2", 3'b010, 8'd2, 1'b0, 3'b000, hv, -1);
    window_run("g1w3", 3'b100, 8'd1, 1'b0, 3'b000, hv, -1);
    chk_done("g1_done", 1'b0);
    chk("g1_length", 32'(cyc - t0), 32'd28);
    tick(2);
    chk_done("g1_done_hold", 1'b0);

    // Game 2: one score at cycle 4 despite repeated/held hits; held sensor
    // gives nothing next window; edge on the final window cycle scores in DONE.
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    hv = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1, 3'd7, 3'd7};
    window_run("g2w1", 3'b001, 8'd3, 1'b0, 3'b000, hv, 4);
    hv = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
    window_run("g2w2", 3'b010, 8'd2, 1'b0, 3'b111, hv, -1);
    hv = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4};
    window_run("g2w3", 3'b100, 8'd1, 1'b0, 3'b000, hv, -1);
    bus.hit_in = 3'b000;
    chk_done("g2_done", 1'b1);
    tick(1);
    chk("g2_done_score_clear", 32'(bus.score_inc), 32'd0);

    // Game 3: hits only on unlit targets, never a score.
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    hv = '{3'd2, 3'd0, 3'd4, 3'd0, 3'd6, 3'd0, 3'd2, 3'd4};
    window_run("g3w1", 3'b001, 8'd3, 1'b0, 3'b000, hv, -1);
    hv = '{3'd1, 3'd0, 3'd4, 3'd0, 3'd5, 3'd0, 3'd1, 3'd4};
    window_run("g3w2", 3'b010, 8'd2, 1'b0, 3'b000, hv, -1);
    hv = '{3'd1, 3'd0, 3'd2, 3'd0, 3'd3, 3'd0, 3'd1, 3'd2};
    window_run("g3w3", 3'b100, 8'd1, 1'b0, 3'b000, hv, -1);
    bus.hit_in = 3'b000;
    chk_done("g3_done", 1'b0);

    // Game 4: lit edge on the last cycle of window 1, then reset in window 2.
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    hv = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    window_run("g4w1", 3'b001, 8'd3, 1'b0, 3'b000, hv, -1);
    // Now in PICK on schedule, carrying the score from the last window cycle.
    chk("g4_pick_score", 32'(bus.score_inc),     32'd1);
    chk("g4_pick_busy",  32'(bus.busy),          32'd1);
    chk("g4_pick_wact",  32'(bus.window_active), 32'd0);
    chk("g4_pick_left",  32'(bus.windows_left),  32'd2);
    bus.hit_in = 3'b000;
    tick(1);
    chk("g4w2_c0_tgt",   32'(bus.target_oh),     32'd2);
    chk("g4w2_c0_wact",  32'(bus.window_active), 32'd1);
    tick(2);
    reset = 1'b1;
    tick(1);
    chk_quiet("g4_reset_abort");
    reset = 1'b0;
    tick(1);
    chk_quiet("g4_after_reset_idle");
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    chk("g5_pick_left", 32'(bus.windows_left), 32'd3);
    chk("g5_pick_busy", 32'(bus.busy),         32'd1);
    tick(1);
    chk("g5_c0_tgt",  32'(bus.target_oh),     32'd1);
    chk("g5_c0_wact", 32'(bus.window_active), 32'd1);
    chk("g5_c0_left", 32'(bus.windows_left),  32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
